// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset controller:
// opcodes, state encodings, datapath select codes and the control bundle.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of controller state (plus mem_ready) into datapath
// controls. JUMP decode exists only when MC_JUMP_EN is defined.
module mc_ctrl_outdec
  import cpu_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b0;
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = ALUSRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        // IR and PC+4 commit only on the cycle the read data is valid
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = ALUSRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regdst     = 1'b0;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.memtoreg   = 1'b0;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = ALUSRCB_B;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsrc       = PCSRC_ALUOUT;
        ctrl.instr_done  = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control FSM: state register and next-state logic.
// Define MC_JUMP_EN to support the j instruction (op = 2) via a JUMP state.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] op,
  input  logic           mem_ready,
  output logic           pcwrite,
  output logic           pcwritecond,
  output logic           iord,
  output logic           memread,
  output logic           memwrite,
  output logic           irwrite,
  output logic           memtoreg,
  output logic           regdst,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic [1:0]     pcsrc,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [STW-1:0] state_o
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
`ifdef MC_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      // any encoding without a case above is treated as corrupted
      default:  state_d = S_IDLE;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pcwrite     = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regdst      = ctrl.regdst;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign aluop       = ctrl.aluop;
  assign pcsrc       = ctrl.pcsrc;
  assign instr_done  = ctrl.instr_done;
  assign state_o     = STW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vector table with a
// scoreboard queue, plus randomized wait-state latency sequences.
module tb_multicycle_control;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3, ST_MEMRD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWR = 4'd6,
    ST_EXEC = 4'd7, ST_ALUWB = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10;

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,
  //  regwrite,alusrca,alusrcb[2],aluop[2],pcsrc[2],instr_done}
  localparam logic [16:0] E_IDLE    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_FETCH_W = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FETCH_R = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
  localparam logic [16:0] E_MEMWR_W = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEMWR_R = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
  localparam logic [16:0] E_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] E_ALUWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
  localparam logic [16:0] E_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
  localparam logic [16:0] E_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
  } row_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, instr_done, illegal_op;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state_o;

  int   checks = 0;
  int   passed = 0;
  row_t rows[$];
  exp_t sb[$];
  int   lat_sb[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  function automatic void add(input logic r, input logic [5:0] o, input logic m,
                              input logic [3:0] s, input logic [16:0] c, input logic il);
    row_t x;
    x.rst_n = r; x.op = o; x.mr = m; x.st = s; x.ctl = c; x.ill = il;
    rows.push_back(x);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s row %0d: got %0h required %0h", name, idx, act, req);
  endtask

  initial begin
    logic [16:0] act;
    exp_t        e;
    rst_n = 1'b0; op = 6'd0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // reset held, released
    add(0, 0, 0, ST_IDLE, E_IDLE, 0);
    add(0, 0, 1, ST_IDLE, E_IDLE, 0);
    add(1, 0, 1, ST_IDLE, E_IDLE, 0);
    // lw, no waits
    add(1, 35, 1, ST_FETCH,  E_FETCH_R, 0);
    add(1, 35, 0, ST_DECODE, E_DECODE,  0);
    add(1, 35, 0, ST_MEMADR, E_MEMADR,  0);
    add(1, 35, 1, ST_MEMRD,  E_MEMRD,   0);
    add(1, 35, 0, ST_MEMWB,  E_MEMWB,   0);
    // sw, three wait cycles in MEMWR
    add(1, 43, 1, ST_FETCH,  E_FETCH_R, 0);
    add(1, 43, 1, ST_DECODE, E_DECODE,  0);
    add(1, 43, 1, ST_MEMADR, E_MEMADR,  0);
    add(1, 43, 0, ST_MEMWR,  E_MEMWR_W, 0);
    add(1, 43, 0, ST_MEMWR,  E_MEMWR_W, 0);
    add(1, 43, 0, ST_MEMWR,  E_MEMWR_W, 0);
    add(1, 43, 1, ST_MEMWR,  E_MEMWR_R, 0);
    // R-type
    add(1, 0, 1, ST_FETCH,  E_FETCH_R, 0);
    add(1, 0, 0, ST_DECODE, E_DECODE,  0);
    add(1, 0, 1, ST_EXEC,   E_EXEC,    0);
    add(1, 0, 0, ST_ALUWB,  E_ALUWB,   0);
    // beq, with one FETCH wait
    add(1, 4, 0, ST_FETCH,  E_FETCH_W, 0);
    add(1, 4, 1, ST_FETCH,  E_FETCH_R, 0);
    add(1, 4, 1, ST_DECODE, E_DECODE,  0);
    add(1, 4, 1, ST_BRANCH, E_BRANCH,  0);
    // illegal op 63
    add(1, 63, 1, ST_FETCH,  E_FETCH_R, 0);
    add(1, 63, 1, ST_DECODE, E_DECODE,  1);
    // op 2
    add(1, 2, 1, ST_FETCH,  E_FETCH_R, 0);
`ifdef MC_JUMP_EN
    add(1, 2, 1, ST_DECODE, E_DECODE,  0);
    add(1, 2, 1, ST_JUMP,   E_JUMP,    0);
`else
    add(1, 2, 1, ST_DECODE, E_DECODE,  1);
`endif
    // reset during a stalled store
    add(1, 43, 1, ST_FETCH,  E_FETCH_R, 0);
    add(1, 43, 1, ST_DECODE, E_DECODE,  0);
    add(1, 43, 1, ST_MEMADR, E_MEMADR,  0);
    add(1, 43, 0, ST_MEMWR,  E_MEMWR_W, 0);
    add(0, 43, 0, ST_MEMWR,  E_MEMWR_W, 0);
    add(1, 43, 0, ST_IDLE,   E_IDLE,    0);
    add(1, 43, 0, ST_FETCH,  E_FETCH_W, 0);

    foreach (rows[i]) begin
      rst_n = rows[i].rst_n; op = rows[i].op; mem_ready = rows[i].mr;
      e.st = rows[i].st; e.ctl = rows[i].ctl; e.ill = rows[i].ill;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      act = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
             regdst, regwrite, alusrca, alusrcb, aluop, pcsrc, instr_done};
      check("state", i, 32'(state_o), 32'(e.st));
      check("ctrl", i, 32'(act), 32'(e.ctl));
      check("illegal_op", i, 32'(illegal_op), 32'(e.ill));
      check("rd_wr_excl", i, 32'(memread & memwrite), 32'd0);
      @(posedge clk); #1;
    end

    // lw/sw with random wait states: latency counted to instr_done
    for (int t = 0; t < 4; t++) begin
      int fw, dw, cyc;
      logic done_seen;
      fw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      op = (t % 2 == 1) ? 6'd43 : 6'd35;
      lat_sb.push_back(((t % 2 == 1) ? 4 : 5) + fw + dw);
      cyc = 0;
      done_seen = 1'b0;
      while (!done_seen && cyc < 40) begin
        mem_ready = 1'b1;
        if (state_o == ST_FETCH && fw > 0) begin mem_ready = 1'b0; fw--; end
        if ((state_o == ST_MEMRD || state_o == ST_MEMWR) && dw > 0) begin
          mem_ready = 1'b0; dw--;
        end
        #2;
        cyc++;
        done_seen = instr_done;
        @(posedge clk); #1;
      end
      check("latency", t, 32'(cyc), 32'(lat_sb.pop_front()));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
